// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the serial adder
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - 1-bit full-adder cell
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/full_adder_w.sv
// rtl/full_adder_w.sv - combinational W-bit ripple adder built from 1-bit cells
module full_adder_w #(
   parameter int W = 4
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_carry_in,
   output logic [W-1:0] o_s,
   output logic         o_carry_out
);

   logic [W:0] c;

   assign c[0]        = i_carry_in;
   assign o_carry_out = c[W];

   genvar g;
   generate
      for (g = 0; g < W; g++) begin : g_cell
         full_adder_cell u_cell (
            .a    (i_a[g]),
            .b    (i_b[g]),
            .cin  (c[g]),
            .s    (o_s[g]),
            .cout (c[g+1])
         );
      end
   endgenerate

endmodule

// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - multi-cycle N-bit adder/subtractor, CHUNK bits per clock
module serial_adder_n
   import serial_adder_pkg::*;
#(
   parameter int N     = 16,
   parameter int CHUNK = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_carry_in,
   input  logic         i_sub,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [N-1:0] o_s,
   output logic         o_carry_out,
   output logic         o_overflow
);

   localparam int NCH = N / CHUNK;
   localparam int KW  = cnt_width(NCH);

   generate
      if (N < 1 || CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_bad_params
         $error("serial_adder_n: N must be a positive multiple of CHUNK");
      end
   endgenerate

   state_t           state, next_state;
   logic [N-1:0]     a_q, b_q, s_q;
   logic             carry_q, a_msb, b_msb, carry_out_q, ovf_q, valid_q;
   logic [KW-1:0]    k;
   logic [CHUNK-1:0] a_chunk, b_chunk, sum;
   logic             slice_cout;
   logic             accept, last;

   assign accept = i_valid && (state == ST_IDLE);
   assign last   = (k == KW'(NCH - 1));

   // Select the operand chunk addressed by the chunk counter.
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int i = 0; i < NCH; i++) begin
         if (k == KW'(i)) begin
            a_chunk = a_q[i*CHUNK +: CHUNK];
            b_chunk = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   full_adder_w #(.W(CHUNK)) u_slice (
      .i_a         (a_chunk),
      .i_b         (b_chunk),
      .i_carry_in  (carry_q),
      .o_s         (sum),
      .o_carry_out (slice_cout)
   );

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= next_state;
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (i_valid) next_state = ST_RUN;
         ST_RUN:  if (last)    next_state = ST_DONE;
         ST_DONE: if (i_ready) next_state = ST_IDLE;
         default:              next_state = ST_IDLE;
      endcase
   end

   // Handshake outputs derived from state and the result-valid register.
   always_comb begin
      o_ready = (state == ST_IDLE);
      o_valid = valid_q;
   end

   // Datapath: capture operands (B inverted for subtract), step one chunk per
   // RUN cycle, and publish the flags on the edge that adds the last chunk.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= '0;
         carry_q     <= 1'b0;
         a_msb       <= 1'b0;
         b_msb       <= 1'b0;
         k           <= '0;
         carry_out_q <= 1'b0;
         ovf_q       <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_q     <= i_a;
                  b_q     <= i_sub ? ~i_b : i_b;
                  carry_q <= i_sub ? ~i_carry_in : i_carry_in;
                  a_msb   <= i_a[N-1];
                  b_msb   <= i_sub ? ~i_b[N-1] : i_b[N-1];
                  k       <= '0;
               end
            end
            ST_RUN: begin
               for (int i = 0; i < NCH; i++) begin
                  if (k == KW'(i)) s_q[i*CHUNK +: CHUNK] <= sum;
               end
               carry_q <= slice_cout;
               if (last) begin
                  k           <= '0;
                  carry_out_q <= slice_cout;
                  ovf_q       <= (a_msb == b_msb) && (sum[CHUNK-1] != a_msb);
                  valid_q     <= 1'b1;
               end else begin
                  k <= k + KW'(1);
               end
            end
            ST_DONE: begin
               if (i_ready) valid_q <= 1'b0;
            end
            default: valid_q <= 1'b0;
         endcase
      end
   end

   assign o_s         = s_q;
   assign o_carry_out = carry_out_q;
   assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// tb/tb_serial_adder_n.sv - directed and random checks of serial_adder_n at CHUNK=4, 1, 16
module tb_serial_adder_n;

   localparam int N = 16;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        c;
      logic        v;
   } vec_t;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_valid;
   logic [N-1:0]  i_a, i_b;
   logic          i_carry_in, i_sub, i_ready;
   logic          o_ready     [3];
   logic          o_valid     [3];
   logic [N-1:0]  o_s         [3];
   logic          o_carry_out [3];
   logic          o_overflow  [3];

   int total = 0;
   int bad   = 0;
   int nch [3] = '{4, 16, 1};

   always #5 i_clk = ~i_clk;

   serial_adder_n #(.N(N), .CHUNK(4)) u_dut4 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready[0]),
      .i_a(i_a), .i_b(i_b), .i_carry_in(i_carry_in), .i_sub(i_sub),
      .o_valid(o_valid[0]), .i_ready(i_ready), .o_s(o_s[0]),
      .o_carry_out(o_carry_out[0]), .o_overflow(o_overflow[0]));

   serial_adder_n #(.N(N), .CHUNK(1)) u_dut1 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready[1]),
      .i_a(i_a), .i_b(i_b), .i_carry_in(i_carry_in), .i_sub(i_sub),
      .o_valid(o_valid[1]), .i_ready(i_ready), .o_s(o_s[1]),
      .o_carry_out(o_carry_out[1]), .o_overflow(o_overflow[1]));

   serial_adder_n #(.N(N), .CHUNK(16)) u_dut16 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready[2]),
      .i_a(i_a), .i_b(i_b), .i_carry_in(i_carry_in), .i_sub(i_sub),
      .o_valid(o_valid[2]), .i_ready(i_ready), .o_s(o_s[2]),
      .o_carry_out(o_carry_out[2]), .o_overflow(o_overflow[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: add as plain 17-bit sum; subtract as A - B - borrow with borrow-out
   function automatic logic [17:0] ref_model(input logic [15:0] a, b, input logic cin, sub);
      logic [16:0] r;
      logic        c, v;
      if (!sub) begin
         r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
         c = r[16];
         v = (a[15] == b[15]) && (r[15] != a[15]);
      end else begin
         r = {1'b0, a} - {1'b0, b} - {16'd0, cin};
         c = ~r[16];
         v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      return {v, c, r[15:0]};
   endfunction

   task automatic start_op(input logic [15:0] a, b, input logic cin, sub, input string tag);
      for (int d = 0; d < 3; d++) chk($sformatf("%s ready_before d%0d", tag, d), 32'(o_ready[d]), 1);
      i_a = a; i_b = b; i_carry_in = cin; i_sub = sub; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_a = 16'($urandom); i_b = 16'($urandom);
      i_carry_in = 1'($urandom); i_sub = 1'($urandom);
   endtask

   task automatic do_op(input logic [15:0] a, b, input logic cin, sub,
                        input logic [15:0] es, input logic ec, ev, input bit rel, input string tag);
      int lat [3];
      start_op(a, b, cin, sub, tag);
      lat = '{-1, -1, -1};
      for (int cyc = 1; cyc <= 24; cyc++) begin
         @(posedge i_clk); #1;
         for (int d = 0; d < 3; d++) if (lat[d] < 0 && o_valid[d]) lat[d] = cyc;
         if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      end
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s latency d%0d", tag, d), 32'(lat[d]), 32'(nch[d]));
         chk($sformatf("%s s d%0d", tag, d), 32'(o_s[d]), 32'(es));
         chk($sformatf("%s carry d%0d", tag, d), 32'(o_carry_out[d]), 32'(ec));
         chk($sformatf("%s ovf d%0d", tag, d), 32'(o_overflow[d]), 32'(ev));
      end
      if (rel) begin
         i_ready = 1'b1;
         @(posedge i_clk); #1;
         i_ready = 1'b0;
         for (int d = 0; d < 3; d++) chk($sformatf("%s valid_clear d%0d", tag, d), 32'(o_valid[d]), 0);
      end
   endtask

   vec_t vecs [8];

   initial begin
      logic [17:0] r;
      logic [15:0] ra, rb;
      logic        rc, rs;

      vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
      vecs[6] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
      vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

      i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
      i_a = '0; i_b = '0; i_carry_in = 1'b0; i_sub = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset ready d%0d", d), 32'(o_ready[d]), 1);
         chk($sformatf("reset valid d%0d", d), 32'(o_valid[d]), 0);
         chk($sformatf("reset s d%0d", d), 32'(o_s[d]), 0);
         chk($sformatf("reset carry d%0d", d), 32'(o_carry_out[d]), 0);
         chk($sformatf("reset ovf d%0d", d), 32'(o_overflow[d]), 0);
      end
      repeat (2) @(posedge i_clk);
      #1 i_rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
               vecs[i].s, vecs[i].c, vecs[i].v, 1'b1, $sformatf("vec%0d", i));

      // Backpressure: hold the result while new requests are offered.
      do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, "bp");
      for (int c = 0; c < 5; c++) begin
         i_valid = 1'b1; i_a = 16'hAAAA; i_b = 16'h5555; i_sub = 1'b0; i_carry_in = 1'b1;
         @(posedge i_clk); #1;
         chk($sformatf("bp hold s c%0d", c), 32'(o_s[0]), 32'h2233);
         chk($sformatf("bp hold valid c%0d", c), 32'(o_valid[0]), 1);
         chk($sformatf("bp hold ready c%0d", c), 32'(o_ready[0]), 0);
      end
      i_valid = 1'b0; i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      chk("bp release ready", 32'(o_ready[0]), 1);
      chk("bp release valid", 32'(o_valid[0]), 0);
      chk("bp release s kept", 32'(o_s[0]), 32'h2233);
      repeat (6) @(posedge i_clk);
      #1;
      chk("bp request not queued", 32'(o_valid[0]), 0);
      chk("bp still idle", 32'(o_ready[0]), 1);

      // Reset while chunk 2 is being added aborts the operation.
      start_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, "rst");
      repeat (2) @(posedge i_clk);
      #1 i_rst_n = 1'b0;
      #1;
      chk("rst valid", 32'(o_valid[0]), 0);
      chk("rst s", 32'(o_s[0]), 0);
      chk("rst ready", 32'(o_ready[0]), 1);
      @(posedge i_clk); #1 i_rst_n = 1'b1;
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, "after_rst");

      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         rc = 1'($urandom);  rs = 1'($urandom);
         r  = ref_model(ra, rb, rc, rs);
         do_op(ra, rb, rc, rs, r[15:0], r[16], r[17], 1'b1, $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
Multi-cycle N-bit adder/subtractor that processes CHUNK bits per clock, LSB chunk first, through one CHUNK-wide ripple slice built from 1-bit full-adder cells. It holds the carry in a register between chunks.
Operands enter and results leave over valid/ready handshakes. Intended for datapaths that trade latency for area, such as accumulators and address units.
Results are 2's-complement, with carry and signed-overflow flags.

Parameters:
N, 16, operand/result width in bits; N >= 1.
CHUNK, 4, bits added per cycle; 1 <= CHUNK <= N and N % CHUNK == 0 (elaboration-time assertion).

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_valid  input  1  operand request valid.
o_ready  output  1  block can accept operands.
i_a  input  N  operand A.
i_b  input  N  operand B.
i_carry_in  input  1  carry-in in add mode; borrow-in in sub mode.
i_sub  input  1  0: A+B+cin; 1: A-B-borrow.
o_valid  output  1  result valid.
i_ready  input  1  consumer accepts result.
o_s  output  N  sum/difference.
o_carry_out  output  1  raw carry out of MSB; in sub mode 1 means no borrow.
o_overflow  output  1  signed overflow.

Behaviour:
- Clock/reset: one clock domain (i_clk). Reset is asynchronous, active-low (i_rst_n).
- Reset values: state IDLE, o_valid=0, o_s=0, o_carry_out=0, o_overflow=0, chunk counter=0, carry register=0.
- Reset mid-operation aborts the operation; no result is produced.
- o_ready = (state==IDLE). It is combinational from state, so it reads 1 during and after reset.
- NCH = N/CHUNK chunks.
- State IDLE:
  - On i_valid && o_ready, capture A and B' = i_sub ? ~i_b : i_b.
  - Carry register loads i_sub ? ~i_carry_in : i_carry_in.
  - Latch the MSBs of A and B' for overflow.
  - Counter := 0. Go to RUN.
- State RUN:
  - Each cycle, add chunk k of A and B' plus the carry register.
  - Write the CHUNK sum bits into result bits [k*CHUNK +: CHUNK].
  - Carry register := slice carry out. k := k+1.
  - When k==NCH-1, the edge that processes the last chunk also:
    - sets o_carry_out to the final carry;
    - sets o_overflow = (A_msb==B'_msb) && (S_msb!=A_msb);
    - sets o_valid=1;
    - moves to DONE.
- State DONE:
  - o_s, o_carry_out and o_overflow stay stable while o_valid=1.
  - On i_ready: o_valid:=0, go to IDLE. o_s and the flags keep their last values.
- Latency: operands accepted at edge 0 -> o_valid high after edge NCH (NCH cycles). Throughput: one operation per NCH+2 cycles at most.
- Boundary conditions:
  - CHUNK==N: a single RUN cycle.
  - CHUNK==1: a pure bit-serial adder.
  - i_valid while busy (RUN/DONE): ignored, not queued. The producer must hold i_valid until it sees o_ready.
  - i_ready while in IDLE/RUN: ignored.
  - Operand inputs are don't-care outside the accept cycle. Captured values are immune to later input changes.
  - Counter and result wrap: k never exceeds NCH-1. No other wrap-around exists.
  - Results are modulo 2^N.

Decomposition:
- Package serial_adder_pkg:
  - state enum typedef (IDLE, RUN, DONE, 2 bits);
  - function clog2-based counter-width helper.
- Sub-module full_adder_w:
  - parameter W;
  - combinational W-bit ripple adder;
  - inputs i_a[W], i_b[W], i_carry_in; outputs o_s[W], o_carry_out;
  - built as a generate loop of the team's existing 1-bit full-adder cell.
- serial_adder_n instantiates one full_adder_w with W=CHUNK.

Test Plan:
- N=16,CHUNK=4: A=0x1234, B=0x0FFF, cin=0, add -> o_valid exactly 4 cycles after accept; o_s=0x2233, carry=0, ovf=0.
- A=0xFFFF, B=0x0001, add, cin=0 -> o_s=0x0000, carry=1, ovf=0. A=0x7FFF, B=0x0001 -> o_s=0x8000, carry=0, ovf=1.
- Sub: A=0x0005, B=0x0007, borrow=0 -> o_s=0xFFFE, carry=0, ovf=0. A=0x8000, B=0x0001 -> o_s=0x7FFF, carry=1, ovf=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE and pulse i_valid with new operands -> outputs stable, o_ready=0, new request not taken. Then i_ready=1 -> IDLE next cycle, o_ready=1.
- Deassert i_rst_n during RUN (chunk 2) -> immediately o_valid=0, o_s=0, o_ready=1. The next operation computes correctly.
- Re-run the first scenario with CHUNK=1 (latency 16) and CHUNK=16 (latency 1) -> identical o_s and flags. Then run 1000 random operations against a reference model.
